// File: rtl/sprite_pkg.sv
// Shared types and register map for the double-buffered sprite descriptor file.
package sprite_pkg;

    localparam int NUM_SPRITES_DEFAULT = 30;

    typedef logic [31:0] sprite_desc_t;

    localparam logic [5:0] ADDR_CLEAR   = 6'd60;
    localparam logic [5:0] ADDR_STATUS  = 6'd61;
    localparam logic [5:0] ADDR_COMMIT  = 6'd62;
    localparam logic [5:0] ADDR_IRQ_ACK = 6'd63;

    function automatic sprite_desc_t pack_status(input logic [15:0] frame_count,
                                                 input logic        irq_pending,
                                                 input logic        commit_pending,
                                                 input logic        vs_sync_low);
        return {frame_count, 13'b0, irq_pending, commit_pending, vs_sync_low};
    endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous active-low vsync into clk and flags its falling edge.
module vsync_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic vs_n_async,
    output logic vs_low,
    output logic vs_edge
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // Reset to "vsync deasserted" so release never manufactures an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= vs_n_async;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign vs_low  = ~sync2;
    assign vs_edge = sync_d & ~sync2;

endmodule

// File: rtl/sprite_regfile_dbuf.sv
// Avalon-slave sprite table: CPU writes a shadow copy, vsync commits it to the active copy.
// Optional frame interrupt is built when FRAME_IRQ_EN is defined.
module sprite_regfile_dbuf
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    input  logic [5:0]                address,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic                      vga_vs_n,
    output logic [NUM_SPRITES*32-1:0] sprite_flat,
    output logic                      frame_irq
);

    sprite_desc_t shadow [NUM_SPRITES];
    sprite_desc_t active [NUM_SPRITES];
    logic         commit_pending;
    logic         irq_pending;
    logic [15:0]  frame_count;
    logic         vs_low;
    logic         vs_edge;
    logic         wr_en;
    logic         rd_en;
    logic         commit;
    sprite_desc_t rd_mux;

    // Bus: a cycle with chipselect and write (or read) high is one transfer; the
    // slave never stalls, and read data appears on readdata one clock later and holds.
    assign wr_en  = chipselect & write;
    assign rd_en  = chipselect & read;
    assign commit = vs_edge & commit_pending;

    vsync_edge_sync u_vsync (
        .clk        (clk),
        .reset      (reset),
        .vs_n_async (vga_vs_n),
        .vs_low     (vs_low),
        .vs_edge    (vs_edge)
    );

    // Non-blocking update lets a coincident commit capture the pre-write shadow.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (reset) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end else begin
                if (wr_en && address == ADDR_CLEAR)
                    shadow[i] <= '0;
                else if (wr_en && address == 6'(i))
                    shadow[i] <= writedata;
                if (commit)
                    active[i] <= shadow[i];
            end
        end
    end

    // An arm write sharing the cycle with vsync wins, so it waits for the next frame.
    always_ff @(posedge clk) begin
        if (reset)
            commit_pending <= 1'b0;
        else if (wr_en && address == ADDR_COMMIT && writedata[0])
            commit_pending <= 1'b1;
        else if (commit)
            commit_pending <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            frame_count <= '0;
        else if (vs_edge)
            frame_count <= frame_count + 16'd1;
    end

`ifdef FRAME_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset)
            irq_pending <= 1'b0;
        else if (wr_en && address == ADDR_IRQ_ACK)
            irq_pending <= 1'b0;
        else if (vs_edge)
            irq_pending <= 1'b1;
    end
`else
    assign irq_pending = 1'b0;
`endif

    assign frame_irq = irq_pending;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (address == 6'(i))
                rd_mux = shadow[i];
        end
        if (address == ADDR_STATUS)
            rd_mux = pack_status(frame_count, irq_pending, commit_pending, vs_low);
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= rd_mux;
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
        assign sprite_flat[32*g +: 32] = active[g];
    end

endmodule

// File: tb/tb_sprite_regfile_dbuf.sv
// Directed bench for sprite_regfile_dbuf: reference model of shadow/active tables,
// read scoreboard queue, and immediate-assertion checks against the model.
module tb_sprite_regfile_dbuf;
    import sprite_pkg::*;

    localparam int NS = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [5:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              vga_vs_n;
    logic [NS*32-1:0]  sprite_flat;
    logic              frame_irq;

    always #10 clk = ~clk;

    sprite_regfile_dbuf #(.NUM_SPRITES(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .vga_vs_n    (vga_vs_n),
        .sprite_flat (sprite_flat),
        .frame_irq   (frame_irq)
    );

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sh_m  [NS];
    logic [31:0] act_m [NS];
    logic        pend_m;
    logic        irq_m;
    logic        vs_low_m;
    logic [15:0] fc_m;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            sh_m[i]  = '0;
            act_m[i] = '0;
        end
        pend_m = 1'b0;
        irq_m  = 1'b0;
        fc_m   = '0;
    endtask

    function automatic logic [31:0] rd_exp(input logic [5:0] a);
        if (int'(a) < NS) return sh_m[a];
        if (a == 6'd61) return {fc_m, 13'b0, irq_m, pend_m, vs_low_m};
        return 32'h0;
    endfunction

    task automatic model_wr(input logic [5:0] a, input logic [31:0] d);
        if (int'(a) < NS) sh_m[a] = d;
        else if (a == 6'd60) begin
            for (int i = 0; i < NS; i++) sh_m[i] = '0;
        end else if (a == 6'd62 && d[0]) pend_m = 1'b1;
`ifdef FRAME_IRQ_EN
        else if (a == 6'd63) irq_m = 1'b0;
`endif
    endtask

    task automatic model_vs_edge();
        if (pend_m) begin
            for (int i = 0; i < NS; i++) act_m[i] = sh_m[i];
            pend_m = 1'b0;
        end
        fc_m = fc_m + 16'd1;
`ifdef FRAME_IRQ_EN
        irq_m = 1'b1;
`endif
    endtask

    // One bus cycle from a negedge; read expectation is taken before the write lands.
    task automatic bus(input logic w, input logic r, input logic [5:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = w;
        read       = r;
        address    = a;
        writedata  = d;
        if (r) exp_q.push_back(rd_exp(a));
        if (w) model_wr(a, d);
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        if (r) begin
            last_rd = exp_q.pop_front();
            check("readdata", readdata, last_rd);
        end
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < NS; i++)
            check(tag, sprite_flat[32*i +: 32], act_m[i]);
        check({tag, "_irq"}, {31'b0, frame_irq}, {31'b0, irq_m});
    endtask

    // Leaves vs_edge live: the next step crosses the commit edge.
    task automatic vs_fall();
        vga_vs_n = 1'b0;
        tick();
        tick();
        vs_low_m = 1'b1;
    endtask

    task automatic vs_rise();
        vga_vs_n = 1'b1;
        tick();
        tick();
        tick();
        vs_low_m = 1'b0;
    endtask

    task automatic pulse();
        vs_fall();
        model_vs_edge();
        tick();
        vs_rise();
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = '0;
        writedata  = '0;
        vga_vs_n   = 1'b1;
        vs_low_m   = 1'b0;
        last_rd    = '0;
        model_reset();
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        check_active("reset_active");
        reset = 1'b0;
        tick();

        // Shadow write without commit leaves active untouched
        bus(1, 0, 6'd3, 32'h12345678);
        pulse();
        check_active("no_commit");
        bus(0, 1, 6'd3, 32'h0);
        tick();
        check("rd_hold", readdata, last_rd);

        // Armed commit lands on the third edge after vsync goes low
        bus(1, 0, 6'd0, 32'hA);
        bus(1, 0, 6'd62, 32'h1);
        vs_fall();
        check("pre_commit", sprite_flat[31:0], act_m[0]);
        model_vs_edge();
        tick();
        check_active("commit");
        vs_rise();
        bus(0, 1, 6'd61, 32'h0);

        // Shadow write on the commit cycle: active takes the old value
        bus(1, 0, 6'd5, 32'h1111);
        bus(1, 0, 6'd62, 32'h1);
        pulse();
        bus(1, 0, 6'd5, 32'h2222);
        bus(1, 0, 6'd62, 32'h1);
        vs_fall();
        model_vs_edge();
        bus(1, 0, 6'd5, 32'hBEEF);
        check_active("wr_on_commit");
        vs_rise();
        bus(0, 1, 6'd5, 32'h0);

        // Arm on the vsync edge defers to the next frame
        bus(1, 0, 6'd7, 32'h7777);
        vs_fall();
        model_vs_edge();
        bus(1, 0, 6'd62, 32'h1);
        check_active("arm_on_edge");
        vs_rise();
        bus(0, 1, 6'd61, 32'h0);
        pulse();
        check_active("deferred_commit");
        bus(0, 1, 6'd61, 32'h0);

        // Clear on the commit cycle commits the pre-clear contents
        bus(1, 0, 6'd8, 32'h8888);
        bus(1, 0, 6'd62, 32'h1);
        vs_fall();
        model_vs_edge();
        bus(1, 0, 6'd60, 32'h0);
        check_active("clear_on_commit");
        vs_rise();
        bus(0, 1, 6'd8, 32'h0);
        bus(0, 1, 6'd0, 32'h0);

        // Unmapped and out-of-range writes, disarm write ignored
        bus(1, 0, 6'd30, 32'hDEAD0030);
        bus(1, 0, 6'd40, 32'hDEAD0040);
        bus(1, 0, 6'd59, 32'hDEAD0059);
        bus(1, 0, 6'd61, 32'hFFFFFFFF);
        bus(1, 0, 6'd62, 32'hFFFFFFFE);
        bus(0, 1, 6'd40, 32'h0);
        bus(0, 1, 6'd61, 32'h0);
        pulse();
        check_active("unmapped");

        // Simultaneous read and write returns pre-write data
        bus(1, 1, 6'd9, 32'h9999);
        bus(0, 1, 6'd9, 32'h0);
        bus(1, 1, 6'd29, 32'h2929);
        bus(0, 1, 6'd29, 32'h0);

        // Interrupt acknowledge, including ack coincident with vsync
        check("irq_level", {31'b0, frame_irq}, {31'b0, irq_m});
        bus(1, 0, 6'd63, 32'h0);
        check("irq_ack", {31'b0, frame_irq}, {31'b0, irq_m});
        pulse();
        check("irq_set", {31'b0, frame_irq}, {31'b0, irq_m});
        vs_fall();
        model_vs_edge();
        bus(1, 0, 6'd63, 32'h0);
        check("irq_ack_wins", {31'b0, frame_irq}, {31'b0, irq_m});
        vs_rise();

        // Frame counter wrap from near the top of its range
        force dut.frame_count = 16'hFFFE;
        #1;
        release dut.frame_count;
        fc_m = 16'hFFFE;
        tick();
        pulse();
        bus(0, 1, 6'd61, 32'h0);
        pulse();
        bus(0, 1, 6'd61, 32'h0);
        check("irq_after_wrap", {31'b0, frame_irq}, {31'b0, irq_m});
        bus(1, 0, 6'd63, 32'h0);
        check("irq_cleared", {31'b0, frame_irq}, {31'b0, irq_m});

        // Reset mid-frame with a commit pending
        bus(1, 0, 6'd1, 32'h1234);
        bus(1, 0, 6'd62, 32'h1);
        bus(0, 1, 6'd1, 32'h0);
        vga_vs_n = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        model_reset();
        check("rst_readdata", readdata, 32'h0);
        check_active("rst_active");
        reset = 1'b0;
        bus(1, 0, 6'd1, 32'h77);
        tick();
        model_vs_edge();
        tick();
        check_active("no_commit_after_rst");
        vs_low_m = 1'b1;
        bus(0, 1, 6'd61, 32'h0);
        vs_rise();
        bus(0, 1, 6'd1, 32'h0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL exp_q_drain: observed %0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
